// File: rtl/win_pkg.sv
`default_nettype none
// ------------------------------------------------------------
// win_pkg: shared constants, state encoding and tap offsets
// Rev 1.0
// ------------------------------------------------------------
package win_pkg;

  localparam int N_DEFAULT  = 64;
  localparam int DW_DEFAULT = 8;
  localparam int NTAPS      = 9;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_DRAIN = 3'd2,
    S_EMIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Tap k sits at (i + C_ROW_OFF[k], j + C_COL_OFF[k]); t0 is the upper-left corner
  localparam logic signed [1:0] C_ROW_OFF [NTAPS] = '{
    -2'sd1, -2'sd1, -2'sd1, 2'sd0, 2'sd0, 2'sd0, 2'sd1, 2'sd1, 2'sd1};
  localparam logic signed [1:0] C_COL_OFF [NTAPS] = '{
    -2'sd1, 2'sd0, 2'sd1, -2'sd1, 2'sd0, 2'sd1, -2'sd1, 2'sd0, 2'sd1};

endpackage
`default_nettype wire

// File: rtl/win_addr_gen.sv
`default_nettype none
// ------------------------------------------------------------
// win_addr_gen: maps (centre i, j, tap k) to a row-major address
// Rev 1.0
// ------------------------------------------------------------
module win_addr_gen
  import win_pkg::*;
#(
  parameter int N = N_DEFAULT
)(
  input  logic [5:0]  i,
  input  logic [5:0]  j,
  input  logic [3:0]  k,
  output logic [11:0] addr,
  output logic        in_range
);

  logic [3:0]        w_k;
  logic signed [1:0] w_dr;
  logic signed [1:0] w_dc;
  logic signed [6:0] w_row;
  logic signed [6:0] w_col;
  logic              w_row_ok;
  logic              w_col_ok;

  always_comb begin
    w_k   = (k > 4'd8) ? 4'd4 : k;
    w_dr  = C_ROW_OFF[w_k];
    w_dc  = C_COL_OFF[w_k];
    // Validity is decided on the signed neighbour coordinate so edges never wrap
    w_row = $signed({1'b0, i}) + $signed({{5{w_dr[1]}}, w_dr});
    w_col = $signed({1'b0, j}) + $signed({{5{w_dc[1]}}, w_dc});
    w_row_ok = !w_row[6] && ($unsigned(w_row) < 7'(N));
    w_col_ok = !w_col[6] && ($unsigned(w_col) < 7'(N));
    in_range = w_row_ok && w_col_ok;
    addr     = in_range ? (12'(w_row[5:0]) * 12'(N) + 12'(w_col[5:0])) : 12'd0;
  end

endmodule
`default_nettype wire

// File: rtl/window_scan_ctrl.sv
`default_nettype none
// ------------------------------------------------------------
// window_scan_ctrl: scans an NxN frame emitting zero-padded 3x3 windows
// Rev 1.0
// ------------------------------------------------------------
module window_scan_ctrl
  import win_pkg::*;
#(
  parameter int N  = N_DEFAULT,
  parameter int DW = DW_DEFAULT
)(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [11:0]     mem_addr,
  output logic            mem_re,
  input  logic [DW-1:0]   mem_rdata,
  output logic            win_valid,
  input  logic            win_ready,
  output logic [9*DW-1:0] win_data,
  output logic [5:0]      win_i,
  output logic [5:0]      win_j,
  output logic            busy,
  output logic            done
);

  localparam logic [5:0] C_LAST     = 6'(N - 1);
  localparam logic [3:0] C_LAST_TAP = 4'd8;

  state_t          r_state;
  logic [5:0]      r_i;
  logic [5:0]      r_j;
  logic [3:0]      r_k;
  logic [11:0]     r_mem_addr;
  logic            r_mem_re;
  logic            r_re_d;
  logic            r_valid;
  logic            r_busy;
  logic            r_done;
  logic [9*DW-1:0] r_taps;

  logic [5:0]      w_ni;
  logic [5:0]      w_nj;
  logic [5:0]      w_gi;
  logic [5:0]      w_gj;
  logic [3:0]      w_gk;
  logic [11:0]     w_addr;
  logic            w_in_range;
  logic [DW-1:0]   w_tap;
  logic            w_last;

  // The address generator always looks one tap ahead so the bus is registered
  always_comb begin
    w_last = (r_i == C_LAST) && (r_j == C_LAST);
    w_nj   = (r_j == C_LAST) ? 6'd0 : r_j + 6'd1;
    w_ni   = (r_j == C_LAST) ? r_i + 6'd1 : r_i;
    w_gi   = 6'd0;
    w_gj   = 6'd0;
    w_gk   = 4'd0;
    case (r_state)
      S_FETCH: begin
        w_gi = r_i;
        w_gj = r_j;
        w_gk = r_k + 4'd1;
      end
      S_EMIT: begin
        w_gi = w_ni;
        w_gj = w_nj;
      end
      default: ;
    endcase
    w_tap = r_re_d ? mem_rdata : '0;
  end

  win_addr_gen #(.N(N)) u_addr_gen (
    .i        (w_gi),
    .j        (w_gj),
    .k        (w_gk),
    .addr     (w_addr),
    .in_range (w_in_range)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_i        <= 6'd0;
      r_j        <= 6'd0;
      r_k        <= 4'd0;
      r_mem_addr <= 12'd0;
      r_mem_re   <= 1'b0;
      r_re_d     <= 1'b0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_taps     <= '0;
    end else begin
      r_re_d <= r_mem_re;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state    <= S_FETCH;
            r_i        <= 6'd0;
            r_j        <= 6'd0;
            r_k        <= 4'd0;
            r_mem_re   <= w_in_range;
            r_mem_addr <= w_addr;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
          end
        end
        S_FETCH: begin
          // Read data trails its tap by one cycle; shifting in from the top leaves t0 in the LSBs
          if (r_k != 4'd0) r_taps <= {w_tap, r_taps[9*DW-1:DW]};
          if (r_k == C_LAST_TAP) begin
            r_state    <= S_DRAIN;
            r_mem_re   <= 1'b0;
            r_mem_addr <= 12'd0;
          end else begin
            r_k        <= r_k + 4'd1;
            r_mem_re   <= w_in_range;
            r_mem_addr <= w_addr;
          end
        end
        S_DRAIN: begin
          r_taps  <= {w_tap, r_taps[9*DW-1:DW]};
          r_state <= S_EMIT;
          r_valid <= 1'b1;
        end
        S_EMIT: begin
          if (win_ready) begin
            r_valid <= 1'b0;
            if (w_last) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state    <= S_FETCH;
              r_i        <= w_ni;
              r_j        <= w_nj;
              r_k        <= 4'd0;
              r_mem_re   <= w_in_range;
              r_mem_addr <= w_addr;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_addr  = r_mem_addr;
  assign mem_re    = r_mem_re;
  assign win_valid = r_valid;
  assign win_data  = r_taps;
  assign win_i     = r_i;
  assign win_j     = r_j;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_window_scan_ctrl.sv
`default_nettype none
// ------------------------------------------------------------
// tb_window_scan_ctrl: scoreboard bench for the 3x3 window scanner
// Rev 1.0
// ------------------------------------------------------------
module tb_window_scan_ctrl;

  localparam int N  = 64;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            win_ready = 1'b1;
  logic [11:0]     mem_addr;
  logic            mem_re;
  logic [DW-1:0]   mem_rdata = '0;
  logic            win_valid;
  logic [9*DW-1:0] win_data;
  logic [5:0]      win_i;
  logic [5:0]      win_j;
  logic            busy;
  logic            done;

  window_scan_ctrl #(.N(N), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mem_addr  (mem_addr),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .win_data  (win_data),
    .win_i     (win_i),
    .win_j     (win_j),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Memory returns addr[7:0] one cycle after a read; junk otherwise
  always @(posedge clk) mem_rdata <= mem_re ? mem_addr[7:0] : 8'hEE;

  typedef struct { int i; int j; } win_t;

  win_t sb_q[$];
  int   rd_q[$];
  int   n_checks = 0;
  int   n_err = 0;
  int   transfers = 0;
  int   bad_addr = 0;

  localparam int C_A1020 [9] = '{'h253, 'h254, 'h255, 'h293, 'h294, 'h295, 'h2D3, 'h2D4, 'h2D5};

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [71:0] exp_data(input int ci, input int cj);
    logic [71:0] d = '0;
    int r;
    int c;
    for (int k = 0; k < 9; k++) begin
      r = ci + k / 3 - 1;
      c = cj + k % 3 - 1;
      if (r >= 0 && r < N && c >= 0 && c < N) d[k*8 +: 8] = 8'((r * N + c) & 255);
    end
    return d;
  endfunction

  task automatic push_frame();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        sb_q.push_back('{i, j});
  endtask

  task automatic check_reset(input string pfx);
    chk({pfx, "_mem_re"},    72'(mem_re),    72'(0));
    chk({pfx, "_mem_addr"},  72'(mem_addr),  72'(0));
    chk({pfx, "_win_valid"}, 72'(win_valid), 72'(0));
    chk({pfx, "_win_data"},  72'(win_data),  72'(0));
    chk({pfx, "_win_i"},     72'(win_i),     72'(0));
    chk({pfx, "_win_j"},     72'(win_j),     72'(0));
    chk({pfx, "_busy"},      72'(busy),      72'(0));
    chk({pfx, "_done"},      72'(done),      72'(0));
  endtask

  // Monitor: collects read addresses and checks every transferred window
  win_t m_e;
  int   m_idx;
  int   m_bad;
  int   m_r;
  int   m_c;
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_re) rd_q.push_back(int'(mem_addr));
      else if (mem_addr != 12'd0) bad_addr++;
      if (win_valid && win_ready) begin
        transfers++;
        if (sb_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_window: got centre (%0d,%0d) expected none", win_i, win_j);
        end else begin
          m_e = sb_q.pop_front();
          chk("win_centre", 72'({win_i, win_j}), 72'({6'(m_e.i), 6'(m_e.j)}));
          chk("win_data", win_data, exp_data(m_e.i, m_e.j));
          m_idx = 0;
          m_bad = 0;
          for (int k = 0; k < 9; k++) begin
            m_r = m_e.i + k / 3 - 1;
            m_c = m_e.j + k % 3 - 1;
            if (m_r >= 0 && m_r < N && m_c >= 0 && m_c < N) begin
              if (m_idx >= rd_q.size() || rd_q[m_idx] != m_r * N + m_c) m_bad++;
              m_idx++;
            end
          end
          chk("read_count", 72'(rd_q.size()), 72'(m_idx));
          chk("read_addr_errs", 72'(m_bad), 72'(0));
          if (m_e.i == 0 && m_e.j == 0)
            chk("data_0_0", win_data, 72'h414000010000000000);
          if (m_e.i == 63 && m_e.j == 63) begin
            chk("data_63_63", win_data, 72'h00000000FFFE00BFBE);
            chk("reads_63_63", 72'(rd_q.size()), 72'(4));
          end
          if (m_e.i == 10 && m_e.j == 20) begin
            m_bad = 0;
            for (int k = 0; k < 9; k++)
              if (k >= rd_q.size() || rd_q[k] != C_A1020[k]) m_bad++;
            chk("addr_10_20", 72'(m_bad), 72'(0));
          end
        end
        rd_q.delete();
      end
    end
  end

  int lat;
  int cyc;
  int base;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Full frame with a stall and ignored start pulses
    push_frame();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!win_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    chk("first_latency", 72'(lat), 72'(10));

    cyc = 0;
    while (transfers < 3 && cyc < 200) begin @(posedge clk); #1; cyc++; end
    win_ready = 1'b0;
    cyc = 0;
    while (!win_valid && cyc < 40) begin @(posedge clk); #1; cyc++; end
    for (int s = 0; s < 5; s++) begin
      start = (s == 2);
      @(posedge clk); #1;
      chk("stall_valid",  72'(win_valid), 72'(1));
      chk("stall_data",   win_data, exp_data(0, 3));
      chk("stall_centre", 72'({win_i, win_j}), 72'({6'd0, 6'd3}));
      chk("stall_mem_re", 72'(mem_re), 72'(0));
    end
    start = 1'b0;
    win_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;

    cyc = 0;
    while (!done && cyc < 50000) begin @(posedge clk); #1; cyc++; end
    chk("frame_done", 72'(done), 72'(1));
    chk("busy_after_done", 72'(busy), 72'(0));
    chk("frame_transfers", 72'(transfers), 72'(4096));
    chk("scoreboard_empty", 72'(sb_q.size()), 72'(0));
    chk("bad_addr_cycles", 72'(bad_addr), 72'(0));

    // Second frame, abandoned by reset during FETCH of (5,5)
    push_frame();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (!(busy && !win_valid && win_i == 6'd5 && win_j == 6'd5) && cyc < 6000) begin
      @(posedge clk); #1; cyc++;
    end
    repeat (3) @(posedge clk);
    #2;
    chk("pre_reset_busy", 72'(busy), 72'(1));
    rst_n = 1'b0;
    #1;
    check_reset("midscan_reset");
    sb_q.delete();
    rd_q.delete();
    repeat (2) @(posedge clk);
    #1;
    chk("held_reset_valid", 72'(win_valid), 72'(0));

    // Start presented on the first edge after reset release
    base = transfers;
    push_frame();
    rst_n = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!win_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    chk("restart_latency", 72'(lat), 72'(10));
    chk("restart_centre", 72'({win_i, win_j}), 72'(0));
    cyc = 0;
    while (transfers < base + 70 && cyc < 2000) begin @(posedge clk); #1; cyc++; end
    chk("restart_transfers", 72'(transfers - base), 72'(70));
    chk("bad_addr_final", 72'(bad_addr), 72'(0));
    rst_n = 1'b0;
    sb_q.delete();
    #1;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/window_scan_ctrl.md
WINDOW_SCAN_CTRL -- requirements
Module: window_scan_ctrl

Interface
REQ-001 Parameter N, default 64: image side length in pixels; power of two, 4..64.
REQ-002 Parameter DW, default 8: pixel data width in bits.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 start  input  1  one-cycle pulse; begins a full-frame scan; honoured only in IDLE or DONE.
REQ-006 mem_addr  output  12  pixel address, row-major, i*N + j.
REQ-007 mem_re  output  1  read strobe; synchronous memory returns mem_rdata exactly 1 cycle after mem_re=1.
REQ-008 mem_rdata  input  DW  read data.
REQ-009 win_valid  output  1  3x3 window for the current centre pixel is presented.
REQ-010 win_ready  input  1  consumer accepts the window; transfer on win_valid & win_ready.
REQ-011 win_data  output  9*DW  taps t0..t8, t0 in LSBs; t0=(i-1,j-1), t1=(i-1,j), t2=(i-1,j+1), t3=(i,j-1), t4=(i,j), t5=(i,j+1), t6=(i+1,j-1), t7=(i+1,j), t8=(i+1,j+1).
REQ-012 win_i, win_j  output  6 each  centre coordinates of the presented window.
REQ-013 busy  output  1  high in every state except IDLE and DONE.
REQ-014 done  output  1  high while in DONE.

Function
REQ-015 FSM states: IDLE, FETCH, DRAIN, EMIT, DONE.
REQ-016 IDLE/DONE --start--> FETCH with i=0, j=0, tap k=0; start in any other state is ignored.
REQ-017 FETCH: one tap per cycle, k=0..8; mem_addr = address of tap k; mem_re=1 only if tap k lies inside 0..N-1 in both axes.
REQ-018 Out-of-range tap: mem_re=0, mem_addr=0, captured tap value = 0 (zero padding); no wrap to the opposite edge or adjacent row.
REQ-019 Data from tap k captured the cycle after tap k is issued; FETCH k=8 --> DRAIN (captures t8) --> EMIT; 10 cycles from FETCH entry to win_valid=1.
REQ-020 EMIT: win_valid=1; win_data, win_i, win_j held stable until win_ready=1.
REQ-021 On transfer: j+1; at j=N-1, j=0 and i+1; after i=N-1, j=N-1 transfer --> DONE, else --> FETCH k=0.
REQ-022 Address arithmetic at 12 bits unsigned; neighbour validity decided on signed 7-bit i±1, j±1 before address formation.
REQ-023 mem_re=0 in IDLE, DRAIN, EMIT, DONE.
REQ-024 Frame throughput: N*N windows; minimum 11 cycles per window with win_ready tied high.

Reset
REQ-025 rst_n=0 forces immediately: state=IDLE, i=j=k=0, mem_re=0, mem_addr=0, win_valid=0, win_data=0, win_i=win_j=0, busy=0, done=0.
REQ-026 Reset mid-scan abandons the frame; no window emitted until a new start after rst_n deasserts.
REQ-027 First rising edge after rst_n rises samples start normally.

Structure
REQ-028 Shared package win_pkg: N, DW, state enum, tap row/column offset table (-1,0,+1).
REQ-029 One sub-module win_addr_gen: combinational (i, j, k) -> (addr[11:0], in_range); no registers.
REQ-030 Controller holds FSM, i/j/k counters and the 9-tap capture register; no other sub-modules.

Verification (memory model: data = addr[7:0], N=64, DW=8)
REQ-031 Reset then start, win_ready=1 -> first win_valid 10 cycles after start; centre (0,0); taps t0,t1,t2,t3,t6 = 0; t4=0x00, t5=0x01, t7=0x40, t8=0x41.
REQ-032 Window centre (10,20) -> mem_re on all 9 taps; addresses 0x253,0x254,0x255,0x293,0x294,0x295,0x2D3,0x2D4,0x2D5 in order.
REQ-033 Centre (63,63) -> t2,t5,t6,t7,t8 = 0 with mem_re=0 on those taps; next transfer enters DONE, done=1, busy=0.
REQ-034 win_ready held 0 for 5 cycles in EMIT -> win_valid, win_data, win_i, win_j unchanged; mem_re=0 throughout.
REQ-035 rst_n pulsed low during FETCH of centre (5,5) -> all outputs at reset values same cycle; restart begins at (0,0).
REQ-036 start pulsed while busy -> ignored, scan order and counts unchanged; full frame yields exactly 4096 transfers.
